spi_txn_sched: RTL and testbench

- Round-robin scheduler plus sequencer that shares one SPI mode-0 link (sensor/config SPI) among NUM_REQ requesters.
- Runs full-duplex DATA_W-bit transfers, MSB first.
- SCLK is generated from a clk_in-domain tick enable, not a gated clock.
- Sits between the register/config masters and the sensor SPI pins on the clk_in domain (about 249 MHz).

---
 rtl/spi_sched_pkg.sv | 27 ++
 rtl/spi_tick_gen.sv | 29 ++
 rtl/spi_txn_sched.sv | 198 +++++++++++++++++++
 tb/tb_spi_txn_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// Shared types and width helpers for the round-robin SPI transaction scheduler.
// Optional loopback build: define SPI_SCHED_LOOPBACK_EN (used in spi_txn_sched).
package spi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Width able to hold a count of 0..2*DATA_W SCLK edges.
  function automatic int bitcnt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

  function automatic int owner_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Enable-pulse divider: one-cycle tick every DIV_RATIO clk_in cycles, held at
// zero while clr is high so the first tick lands DIV_RATIO cycles after release.
module spi_tick_gen #(
  parameter int DIV_RATIO = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_RATIO - 1);

  logic [CW-1:0] cnt_q;

  assign tick = !clr && (cnt_q == LAST);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_txn_sched.sv
// Round-robin arbiter plus SPI mode-0 sequencer sharing one link among NUM_REQ
// requesters. Define SPI_SCHED_LOOPBACK_EN to capture internal MOSI instead of MISO.
module spi_txn_sched
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 16,
  parameter int DIV_RATIO = 2,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic                        clk_in,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic                        spi_sclk,
  output logic                        spi_cs_n,
  output logic                        spi_mosi,
  input  logic                        spi_miso
);

  localparam int OWN_W = owner_w(NUM_REQ);
  localparam int CNT_W = max3(bitcnt_w(DATA_W), $clog2(CS_SETUP + 1), $clog2(CS_HOLD + 1));
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2 * DATA_W - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

  state_t              state_q, state_d;
  logic [OWN_W-1:0]    ptr_q, ptr_d, owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic                busy_q, busy_d, sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;

  logic                tick;
  logic                sample_bit;
  logic [OWN_W-1:0]    sel, ptr_nxt;
  logic                sel_vld;
  int                  idx;
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

`ifdef SPI_SCHED_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign sample_bit  = mosi_q;
`else
  assign sample_bit  = spi_miso;
`endif

  spi_tick_gen #(.DIV_RATIO(DIV_RATIO)) u_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (state_q == IDLE),
    .tick   (tick)
  );

  // Descending scan so the requester closest at/after the pointer wins last.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        sel     = OWN_W'(idx);
        sel_vld = 1'b1;
      end
    end
    ptr_nxt = (int'(sel) == NUM_REQ - 1) ? '0 : OWN_W'(int'(sel) + 1);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    gnt_d   = '0;
    done_d  = '0;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    // Delayed one cycle from the state so cs_n falls the cycle after gnt.
    cs_n_d  = (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        cnt_d  = '0;
        if (sel_vld) begin
          gnt_d[sel] = 1'b1;
          owner_d    = sel;
          tx_d       = wdata_arr[sel];
          rx_d       = '0;
          mosi_d     = wdata_arr[sel][DATA_W-1];
          busy_d     = 1'b1;
          ptr_d      = ptr_nxt;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          if (cnt_q == SETUP_LAST) begin
            cnt_d   = '0;
            state_d = SHIFT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d = {rx_q[DATA_W-2:0], sample_bit};
          end else begin
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d = tx_q[DATA_W-2];
          end
          if (cnt_q == SHIFT_LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d          = '0;
            rdata_d        = rx_q;
            done_d[owner_q] = 1'b1;
            busy_d         = 1'b0;
            mosi_d         = 1'b0;
            state_d        = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_txn_sched.sv
// Directed bench for spi_txn_sched: default instance with a MISO slave model,
// plus a DIV_RATIO=1 instance with MISO tied low.
module tb_spi_txn_sched;

`ifdef SPI_SCHED_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  gnt, done;
  logic [15:0] rdata;
  logic        busy, spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso = 1'b0;

  logic [1:0]  req_f = '0;
  logic [31:0] req_wdata_f = '0;
  logic [1:0]  gnt_f, done_f;
  logic [15:0] rdata_f;
  logic        busy_f, sclk_f, cs_n_f, mosi_f;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  spi_txn_sched u_dut (
    .clk_in(clk_in), .rst(rst), .req(req), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_txn_sched #(.DIV_RATIO(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut_fast (
    .clk_in(clk_in), .rst(rst), .req(req_f), .req_wdata(req_wdata_f),
    .gnt(gnt_f), .done(done_f), .rdata(rdata_f), .busy(busy_f),
    .spi_sclk(sclk_f), .spi_cs_n(cs_n_f), .spi_mosi(mosi_f), .spi_miso(1'b0)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  // Slave model and pin monitor for the default instance.
  logic [15:0] slave_word = '0;
  logic [15:0] sl_sh = '0;
  logic [15:0] mosi_cap = '0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, first_rise = 1'b1;
  int          ncyc = 0, cs_low = 0, last_cs_low = 0, last_rise = 0, sclk_per = 0;

  always @(negedge clk_in) begin
    ncyc++;
    if (prev_cs && !spi_cs_n) begin
      sl_sh      = slave_word;
      spi_miso   = sl_sh[15];
      cs_low     = 0;
      mosi_cap   = '0;
      first_rise = 1'b1;
    end
    if (!prev_cs && spi_cs_n) last_cs_low = cs_low;
    if (!spi_cs_n) cs_low++;
    if (!prev_sclk && spi_sclk) begin
      mosi_cap = {mosi_cap[14:0], spi_mosi};
      if (!first_rise) sclk_per = ncyc - last_rise;
      first_rise = 1'b0;
      last_rise  = ncyc;
    end
    if (prev_sclk && !spi_sclk) begin
      sl_sh    = {sl_sh[14:0], 1'b0};
      spi_miso = sl_sh[15];
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  logic f_prev_cs = 1'b1, f_prev_sclk = 1'b0, f_first = 1'b1;
  int   f_cs_low = 0, f_last_cs_low = 0, f_last_rise = 0, f_per = 0;

  always @(negedge clk_in) begin
    if (f_prev_cs && !cs_n_f) begin
      f_cs_low = 0;
      f_first  = 1'b1;
    end
    if (!f_prev_cs && cs_n_f) f_last_cs_low = f_cs_low;
    if (!cs_n_f) f_cs_low++;
    if (!f_prev_sclk && sclk_f) begin
      if (!f_first) f_per = ncyc - f_last_rise;
      f_first     = 1'b0;
      f_last_rise = ncyc;
    end
    f_prev_cs   = cs_n_f;
    f_prev_sclk = sclk_f;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // which: 0 gnt, 1 done, 2 fast gnt, 3 fast done. Returns at posedge+1.
  task automatic wait_evt(input int which, output int at);
    logic hit;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_in);
      #1;
      case (which)
        0:       hit = |gnt;
        1:       hit = |done;
        2:       hit = |gnt_f;
        default: hit = |done_f;
      endcase
      if (hit) begin
        at = cyc;
        return;
      end
    end
    at = -1;
    n_tests++;
    n_fail++;
    $display("FAIL wait_evt%0d: got timeout expected event within 400 cycles", which);
  endtask

  task automatic single_xfer(input string tag, input int idx, input logic [15:0] wd,
                             input logic [15:0] sw);
    int tg, td;
    logic [15:0] exp_rd;
    exp_rd = LB ? wd : sw;
    @(negedge clk_in);
    slave_word = sw;
    req_wdata[idx*16 +: 16] = wd;
    req[idx] = 1'b1;
    wait_evt(0, tg);
    check({tag, "_gnt"}, 32'(gnt), 32'(1 << idx));
    check({tag, "_cs_at_gnt"}, 32'(spi_cs_n), 32'd1);
    req[idx] = 1'b0;
    @(posedge clk_in);
    #1;
    check({tag, "_cs_fall"}, 32'(spi_cs_n), 32'd0);
    check({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_evt(1, td);
    check({tag, "_done"}, 32'(done), 32'(1 << idx));
    check({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk_in);
    #1;
    check({tag, "_cs_low"}, 32'(last_cs_low), 32'd72);
    check({tag, "_mosi"}, 32'(mosi_cap), 32'(wd));
    check({tag, "_sclk_per"}, 32'(sclk_per), 32'd4);
    $display("[TB] xfer %s req%0d wdata=%h rdata=%h cs_low=%0d", tag, idx, wd, rdata, last_cs_low);
  endtask

  int own_seq [5] = '{0, 1, 0, 1, 0};
  int tg, td, ndone;
  logic [15:0] exp_rd;

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    @(negedge clk_in);
    rst = 1'b0;

    single_xfer("single0", 0, 16'hA5C3, 16'h3C5A);
    single_xfer("loopchk", 1, 16'h1234, 16'hFFFF);

    // Both held: strict alternation, then only req0 left after granting 1.
    @(negedge clk_in);
    slave_word = 16'hC3A5;
    req_wdata  = {16'h7FFE, 16'h8001};
    req        = 2'b11;
    td         = 0;
    for (int t = 0; t < 5; t++) begin
      wait_evt(0, tg);
      check($sformatf("rr%0d_gnt", t), 32'(gnt), 32'(1 << own_seq[t]));
      if (t > 0) check($sformatf("rr%0d_gap", t), 32'(tg - td), 32'd1);
      if (t == 3) req = 2'b01;
      else if (t == 4) req = 2'b00;
      wait_evt(1, td);
      exp_rd = LB ? req_wdata[own_seq[t]*16 +: 16] : slave_word;
      check($sformatf("rr%0d_done", t), 32'(done), 32'(1 << own_seq[t]));
      check($sformatf("rr%0d_rdata", t), 32'(rdata), 32'(exp_rd));
      $display("[TB] xfer rr%0d owner=%0d gnt_cyc=%0d done_cyc=%0d rdata=%h", t, own_seq[t], tg, td, rdata);
    end

    // Abort mid-transfer with reset.
    @(negedge clk_in);
    slave_word = 16'h1357;
    req_wdata[15:0] = 16'hBEEF;
    req = 2'b01;
    wait_evt(0, tg);
    req = 2'b00;
    repeat (29) @(posedge clk_in);
    #1;
    check("abort_cs_before", 32'(spi_cs_n), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_in);
      #1;
      if (|done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    $display("[TB] xfer abort owner=0 reset at cycle 30, done pulses=%0d", ndone);

    @(negedge clk_in);
    slave_word = 16'h2468;
    req_wdata  = {16'h0F0F, 16'hF00D};
    req        = 2'b11;
    wait_evt(0, tg);
    check("post_rst_gnt", 32'(gnt), 32'd1);
    req = 2'b00;
    wait_evt(1, td);
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_rdata", 32'(rdata), 32'(LB ? 16'hF00D : 16'h2468));
    $display("[TB] xfer post_rst owner=0 rdata=%h", rdata);

    // Fastest divider: SCLK = clk_in/2, MISO tied low.
    @(negedge clk_in);
    req_wdata_f[15:0] = 16'hFFFF;
    req_f = 2'b01;
    wait_evt(2, tg);
    check("fast_gnt", 32'(gnt_f), 32'd1);
    check("fast_mosi_msb", 32'(mosi_f), 32'd1);
    req_f = 2'b00;
    @(posedge clk_in);
    #1;
    check("fast_busy", 32'(busy_f), 32'd1);
    wait_evt(3, td);
    check("fast_done", 32'(done_f), 32'd1);
    check("fast_rdata", 32'(rdata_f), 32'(LB ? 16'hFFFF : 16'h0000));
    repeat (2) @(negedge clk_in);
    #1;
    check("fast_cs_low", 32'(f_last_cs_low), 32'd34);
    check("fast_sclk_per", 32'(f_per), 32'd2);
    $display("[TB] xfer fast req0 wdata=ffff rdata=%h cs_low=%0d", rdata_f, f_last_cs_low);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
